// File: rtl/jpeg_pkg.sv
// Shared widths, types and rounding helper for the JPEG quantization stage.
package jpeg_pkg;
    localparam int COEF_W  = 12;
    localparam int RECIP_W = 16;
    localparam int FRAC    = 15;
    localparam int BLK_LEN = 64;
    localparam int IDX_W   = $clog2(BLK_LEN);
    localparam int PROD_W  = COEF_W + RECIP_W + 1;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic        [RECIP_W-1:0] recip_t;
    typedef logic signed [PROD_W-1:0]  prod_t;

    localparam recip_t RECIP_ONE = 16'h8000;
    localparam prod_t  Q_MAX     = prod_t'((1 << (COEF_W-1)) - 1);
    localparam prod_t  Q_MIN     = -Q_MAX - prod_t'(1);
    localparam prod_t  HALF      = prod_t'(1 << (FRAC-1));

    // Rounds |p| so that halves move away from zero, then clamps to coef range.
    function automatic coef_t round_half_away(input prod_t p);
        prod_t mag;
        prod_t r;
        prod_t q;
        coef_t res;
        mag = p[PROD_W-1] ? -p : p;
        r   = (mag + HALF) >> FRAC;
        q   = p[PROD_W-1] ? -r : r;
        if (q > Q_MAX)      res = coef_t'(Q_MAX);
        else if (q < Q_MIN) res = coef_t'(Q_MIN);
        else                res = coef_t'(q);
        return res;
    endfunction
endpackage

// File: rtl/jpeg_qt_ram.sv
// 64-entry reciprocal table: synchronous write, registered read (old data on collision).
module jpeg_qt_ram
    import jpeg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  recip_t           wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output recip_t           rdata_o
);
    recip_t tbl_q [BLK_LEN];
    recip_t rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BLK_LEN; i++) tbl_q[i] <= RECIP_ONE;
            rdata_q <= '0;
        end else begin
            if (we_i) tbl_q[waddr_i] <= wdata_i;
            rdata_q <= tbl_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/jpeg_zz_quant.sv
// Zig-zag coefficient quantizer: index tracking, framing check, and a 3-stage
// multiply-by-reciprocal / round / saturate pipeline.
module jpeg_zz_quant
    import jpeg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sob,
    input  coef_t            in_data,
    input  logic             qt_we,
    input  logic [IDX_W-1:0] qt_addr,
    input  recip_t           qt_data,
    input  logic             err_clr,
    output logic             out_valid,
    output logic             out_sob,
    output logic             out_eob,
    output coef_t            out_data,
    output logic             blk_err
);
    localparam int STAGES = 3;

    logic [STAGES:1]  vld_pipe_q;
    logic [IDX_W-1:0] idx_q, idx_d, idx_cur;
    logic             blk_err_q, blk_err_d, err_set;
    coef_t            coef_s1_q;
    logic             sob_s1_q, eob_s1_q;
    recip_t           recip_s1;
    prod_t            prod_d, prod_s2_q;
    logic             sob_s2_q, eob_s2_q;
    coef_t            out_data_q;
    logic             out_sob_q, out_eob_q;

    // Table read is addressed by the beat's own index so it lands alongside S1.
    jpeg_qt_ram u_qt_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (qt_we),
        .waddr_i (qt_addr),
        .wdata_i (qt_data),
        .raddr_i (idx_cur),
        .rdata_o (recip_s1)
    );

    always_comb begin
        idx_cur   = in_sob ? '0 : idx_q;
        idx_d     = idx_q;
        if (in_valid) idx_d = idx_cur + 1'b1;
        err_set   = in_valid & in_sob & (idx_q != '0);
        blk_err_d = err_set | (blk_err_q & ~err_clr);
        prod_d    = prod_t'(coef_s1_q) * prod_t'({1'b0, recip_s1});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            idx_q      <= '0;
            blk_err_q  <= 1'b0;
            coef_s1_q  <= '0;
            sob_s1_q   <= 1'b0;
            eob_s1_q   <= 1'b0;
            prod_s2_q  <= '0;
            sob_s2_q   <= 1'b0;
            eob_s2_q   <= 1'b0;
            out_data_q <= '0;
            out_sob_q  <= 1'b0;
            out_eob_q  <= 1'b0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_valid};
            idx_q      <= idx_d;
            blk_err_q  <= blk_err_d;
            coef_s1_q  <= in_data;
            sob_s1_q   <= in_valid & in_sob;
            eob_s1_q   <= idx_cur == IDX_W'(BLK_LEN-1);
            prod_s2_q  <= prod_d;
            sob_s2_q   <= sob_s1_q;
            eob_s2_q   <= eob_s1_q;
            // Output fields only move on a valid beat so they hold through bubbles.
            if (vld_pipe_q[STAGES-1]) begin
                out_data_q <= round_half_away(prod_s2_q);
                out_sob_q  <= sob_s2_q;
                out_eob_q  <= eob_s2_q;
            end
        end
    end

    assign out_valid = vld_pipe_q[STAGES];
    assign out_sob   = out_sob_q;
    assign out_eob   = out_eob_q;
    assign out_data  = out_data_q;
    assign blk_err   = blk_err_q;
endmodule

// File: tb/tb_jpeg_zz_quant.sv
// Directed bench for jpeg_zz_quant: identity, Q=16 rounding, saturation edges,
// framing errors, table write collision and mid-block reset.
module tb_jpeg_zz_quant;
    import jpeg_pkg::*;

    logic             clk = 1'b0;
    logic             rst, in_valid, in_sob, qt_we, err_clr;
    coef_t            in_data;
    logic [IDX_W-1:0] qt_addr;
    recip_t           qt_data;
    logic             out_valid, out_sob, out_eob, blk_err;
    coef_t            out_data;

    jpeg_zz_quant dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sob(in_sob), .in_data(in_data),
        .qt_we(qt_we), .qt_addr(qt_addr), .qt_data(qt_data), .err_clr(err_clr),
        .out_valid(out_valid), .out_sob(out_sob), .out_eob(out_eob),
        .out_data(out_data), .blk_err(blk_err)
    );

    always #5 clk = ~clk;

    typedef struct { int d; bit sob; bit eob; int c; } ob_t;
    ob_t oq[$];
    int  cyc = 0;
    int  total = 0, bad = 0;
    int  blk [64];

    always @(negedge clk) begin
        cyc++;
        if (out_valid) oq.push_back('{d: int'(out_data), sob: out_sob, eob: out_eob, c: cyc});
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drive(input bit sob, input int d);
        in_valid = 1'b1; in_sob = sob; in_data = coef_t'(d);
        tick();
        in_valid = 1'b0; in_sob = 1'b0;
    endtask

    task automatic send(input int n, input bit first_sob);
        for (int i = 0; i < n; i++) drive(first_sob && i == 0, blk[i]);
    endtask

    task automatic write_all(input int v);
        for (int i = 0; i < 64; i++) begin
            qt_we = 1'b1; qt_addr = IDX_W'(i); qt_data = recip_t'(v);
            tick();
        end
        qt_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; in_sob = 0; in_data = '0;
        qt_we = 0; qt_addr = '0; qt_data = '0; err_clr = 0;
        idle(3);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data got %0d want 0", out_data); end
        total++; if ({out_sob, out_eob} !== 2'b00) begin bad++; $display("FAIL reset_markers got %b want 00", {out_sob, out_eob}); end
        total++; if (blk_err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", blk_err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_identity();
        int c0;
        for (int i = 0; i < 64; i++) blk[i] = i;
        oq.delete();
        c0 = cyc;
        send(64, 1);
        idle(5);
        total++; if (oq.size() !== 64) begin bad++; $display("FAIL ident_count got %0d want 64", oq.size()); end
        for (int i = 0; i < oq.size() && i < 64; i++) begin
            total++; if (oq[i].d !== i) begin bad++; $display("FAIL ident_data[%0d] got %0d want %0d", i, oq[i].d, i); end
            total++; if (oq[i].sob !== (i == 0)) begin bad++; $display("FAIL ident_sob[%0d] got %b want %b", i, oq[i].sob, i == 0); end
            total++; if (oq[i].eob !== (i == 63)) begin bad++; $display("FAIL ident_eob[%0d] got %b want %b", i, oq[i].eob, i == 63); end
        end
        if (oq.size() > 0) begin
            total++; if (oq[0].c !== c0 + 4) begin bad++; $display("FAIL ident_latency got %0d want %0d", oq[0].c - c0 - 1, 3); end
        end
        total++; if (out_data !== coef_t'(63) || out_eob !== 1'b1) begin bad++; $display("FAIL ident_hold got %0d/%b want 63/1", out_data, out_eob); end
        total++; if (blk_err !== 1'b0) begin bad++; $display("FAIL ident_err got %b want 0", blk_err); end
    endtask

    task automatic test_q16();
        int exp_v [6] = '{6, -6, 2, -2, 1, -1};
        write_all(2048);
        for (int i = 0; i < 64; i++) blk[i] = 0;
        blk[0] = 100; blk[1] = -100; blk[2] = 24; blk[3] = -24; blk[4] = 8; blk[5] = -8;
        oq.delete();
        send(64, 1);
        idle(5);
        total++; if (oq.size() !== 64) begin bad++; $display("FAIL q16_count got %0d want 64", oq.size()); end
        for (int i = 0; i < 6 && i < oq.size(); i++) begin
            total++; if (oq[i].d !== exp_v[i]) begin bad++; $display("FAIL q16_data[%0d] got %0d want %0d", i, oq[i].d, exp_v[i]); end
        end
    endtask

    task automatic test_sat();
        write_all(32768);
        for (int i = 0; i < 64; i++) blk[i] = 0;
        blk[0] = 2047; blk[1] = -2048;
        oq.delete();
        send(64, 1);
        idle(5);
        total++; if (oq.size() !== 64) begin bad++; $display("FAIL sat_count got %0d want 64", oq.size()); end
        if (oq.size() >= 2) begin
            total++; if (oq[0].d !== 2047) begin bad++; $display("FAIL sat_max got %0d want 2047", oq[0].d); end
            total++; if (oq[1].d !== -2048) begin bad++; $display("FAIL sat_min got %0d want -2048", oq[1].d); end
        end
    endtask

    task automatic test_err();
        for (int i = 0; i < 64; i++) blk[i] = 0;
        oq.delete();
        send(40, 1);
        send(64, 1);
        idle(5);
        total++; if (blk_err !== 1'b1) begin bad++; $display("FAIL err_set got %b want 1", blk_err); end
        total++; if (oq.size() !== 104) begin bad++; $display("FAIL err_count got %0d want 104", oq.size()); end
        for (int i = 0; i < oq.size() && i < 104; i++) begin
            total++; if (oq[i].sob !== (i == 0 || i == 40)) begin bad++; $display("FAIL err_sob[%0d] got %b want %b", i, oq[i].sob, i == 0 || i == 40); end
            total++; if (oq[i].eob !== (i == 103)) begin bad++; $display("FAIL err_eob[%0d] got %b want %b", i, oq[i].eob, i == 103); end
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        total++; if (blk_err !== 1'b0) begin bad++; $display("FAIL err_clear got %b want 0", blk_err); end
        send(4, 1);
        err_clr = 1'b1;
        drive(1, 0);
        err_clr = 1'b0;
        total++; if (blk_err !== 1'b1) begin bad++; $display("FAIL err_set_beats_clr got %b want 1", blk_err); end
        send(63, 0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        idle(4);
        total++; if (blk_err !== 1'b0) begin bad++; $display("FAIL err_clear2 got %b want 0", blk_err); end
    endtask

    task automatic test_wr_collision();
        for (int i = 0; i < 64; i++) blk[i] = 0;
        blk[5] = 64;
        oq.delete();
        for (int i = 0; i < 64; i++) begin
            if (i == 5) begin qt_we = 1'b1; qt_addr = 6'd5; qt_data = 16'd4096; end
            drive(i == 0, blk[i]);
            qt_we = 1'b0;
        end
        send(64, 1);
        idle(5);
        total++; if (oq.size() !== 128) begin bad++; $display("FAIL coll_count got %0d want 128", oq.size()); end
        if (oq.size() >= 70) begin
            total++; if (oq[5].d !== 64) begin bad++; $display("FAIL coll_old got %0d want 64", oq[5].d); end
            total++; if (oq[69].d !== 8) begin bad++; $display("FAIL coll_new got %0d want 8", oq[69].d); end
        end
        qt_we = 1'b1; qt_addr = 6'd5; qt_data = RECIP_ONE; tick(); qt_we = 1'b0;
    endtask

    task automatic test_rst_midblock();
        int c0;
        for (int i = 0; i < 64; i++) blk[i] = 0;
        send(2, 0);
        qt_we = 1'b1; qt_addr = 6'd10; qt_data = 16'd4096; tick(); qt_we = 1'b0;
        idle(5);
        oq.delete();
        blk[0] = 10; blk[1] = 20; blk[2] = 30; blk[3] = 40; blk[4] = 50;
        send(5, 1);
        total++; if (blk_err !== 1'b1) begin bad++; $display("FAIL rst_pre_err got %b want 1", blk_err); end
        rst = 1'b1; idle(2); rst = 1'b0;
        idle(6);
        total++; if (oq.size() !== 3) begin bad++; $display("FAIL rst_flush_count got %0d want 3", oq.size()); end
        if (oq.size() >= 3) begin
            total++; if (oq[2].d !== 30) begin bad++; $display("FAIL rst_last_pre got %0d want 30", oq[2].d); end
        end
        total++; if ({out_valid, out_sob, out_eob, blk_err} !== 4'b0000) begin bad++; $display("FAIL rst_ctrl got %b want 0000", {out_valid, out_sob, out_eob, blk_err}); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL rst_data got %0d want 0", out_data); end
        for (int i = 0; i < 64; i++) blk[i] = i * 30 - 1000;
        blk[10] = 100;
        oq.delete();
        c0 = cyc;
        send(64, 1);
        idle(5);
        total++; if (oq.size() !== 64) begin bad++; $display("FAIL post_count got %0d want 64", oq.size()); end
        for (int i = 0; i < oq.size() && i < 64; i++) begin
            total++; if (oq[i].d !== blk[i]) begin bad++; $display("FAIL post_data[%0d] got %0d want %0d", i, oq[i].d, blk[i]); end
            total++; if ({oq[i].sob, oq[i].eob} !== {i == 0, i == 63}) begin bad++; $display("FAIL post_mark[%0d] got %b%b", i, oq[i].sob, oq[i].eob); end
        end
        if (oq.size() > 0) begin
            total++; if (oq[0].c !== c0 + 4) begin bad++; $display("FAIL post_latency got %0d want 3", oq[0].c - c0 - 1); end
        end
        total++; if (blk_err !== 1'b0) begin bad++; $display("FAIL post_err got %b want 0", blk_err); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_q16();
        test_sat();
        test_err();
        test_wr_collision();
        test_rst_midblock();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
